// File: rtl/dual_port_memory_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dual_port_memory_pkg
// Purpose  : Shared types, width helpers and byte-merge function for the
//            dual-port word memory.
// Revision : 1.0 - initial release
// ============================================================================
package dual_port_memory_pkg;

    typedef enum logic [0:0] {
        MEM_INIT  = 1'b0,
        MEM_READY = 1'b1
    } mem_state_t;

    // Widest word the merge helper handles; instances must stay strictly below.
    localparam int c_MAX_WIDTH = 1024;
    localparam int c_MAX_LANES = c_MAX_WIDTH / 8;

    function automatic int lanes_of(input int width);
        return width / 8;
    endfunction

    function automatic int offset_bits_of(input int width);
        return ((width / 8) > 1) ? $clog2(width / 8) : 0;
    endfunction

    function automatic int index_bits_of(input int depth);
        return $clog2(depth);
    endfunction

    function automatic logic [c_MAX_WIDTH-1:0] merge_bytes(
        input logic [c_MAX_WIDTH-1:0] old_word,
        input logic [c_MAX_WIDTH-1:0] new_word,
        input logic [c_MAX_LANES-1:0] mask
    );
        logic [c_MAX_WIDTH-1:0] merged;
        merged = old_word;
        for (int k = 0; k < c_MAX_LANES; k++) begin
            if (mask[k]) begin
                merged[8*k +: 8] = new_word[8*k +: 8];
            end
        end
        return merged;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dual_port_memory_init_fsm.sv
`default_nettype none
// ============================================================================
// Module   : mem_init_fsm
// Purpose  : Post-reset clearing sequencer; walks every word writing zero,
//            then holds READY until the next reset.
// Revision : 1.0 - initial release
// ============================================================================
module mem_init_fsm
    import dual_port_memory_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_BITS    = 10
) (
    input  logic                clk,
    input  logic                rst,
    output logic                o_ready,
    output logic                o_clear_we,
    output logic [IDX_BITS-1:0] o_clear_idx
);

    localparam logic [IDX_BITS-1:0] c_LAST_IDX = IDX_BITS'(DEPTH_WORDS - 1);

    mem_state_t          r_state;
    mem_state_t          w_state_next;
    logic [IDX_BITS-1:0] r_count;
    logic [IDX_BITS-1:0] w_count_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= MEM_INIT;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        o_clear_we   = 1'b0;
        case (r_state)
            MEM_INIT: begin
                o_clear_we   = 1'b1;
                w_count_next = r_count + 1'b1;
                if (r_count == c_LAST_IDX) begin
                    w_state_next = MEM_READY;
                end
            end
            MEM_READY: begin
                w_state_next = MEM_READY;
            end
            default: begin
                w_state_next = MEM_INIT;
            end
        endcase
    end

    assign o_clear_idx = r_count;
    assign o_ready     = (r_state == MEM_READY);

endmodule
`default_nettype wire

// File: rtl/dual_port_memory.sv
`default_nettype none
// ============================================================================
// Module   : dual_port_memory
// Purpose  : Instruction (read-only) + data (byte-masked read/write) word
//            memory with 1-cycle registered reads, write-first forwarding,
//            alignment/range flags and post-reset clearing.
//            Optional per-lane parity: define DUAL_PORT_MEMORY_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dual_port_memory
    import dual_port_memory_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WIDTH       = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    ready,
    input  logic [ADDR_WIDTH-1:0]   iAddress,
    output logic [WIDTH-1:0]        iDataOut,
    input  logic [ADDR_WIDTH-1:0]   dAddress,
    input  logic                    dWriteEnable,
    input  logic [WIDTH/8-1:0]      dByteEnable,
    input  logic [WIDTH-1:0]        dDataIn,
    output logic [WIDTH-1:0]        dDataOut,
    output logic                    dMisaligned,
    output logic                    dOutOfRange,
    output logic                    parityError
);

    localparam int c_LANES       = lanes_of(WIDTH);
    localparam int c_OFFSET_BITS = offset_bits_of(WIDTH);
    localparam int c_IDX_BITS    = index_bits_of(DEPTH_WORDS);
    localparam int c_TOP_BIT     = c_OFFSET_BITS + c_IDX_BITS;

    logic [WIDTH-1:0]       r_mem [DEPTH_WORDS];
    logic                   w_ready;
    logic                   w_clear_we;
    logic [c_IDX_BITS-1:0]  w_clear_idx;
    logic [c_IDX_BITS-1:0]  w_d_idx;
    logic [c_IDX_BITS-1:0]  w_i_idx;
    logic                   w_d_misaligned;
    logic                   w_d_oor;
    logic                   w_i_oor;
    logic                   w_user_we;
    logic [c_MAX_WIDTH-1:0] w_old_ext;
    logic [c_MAX_WIDTH-1:0] w_new_ext;
    logic [c_MAX_LANES-1:0] w_mask_ext;
    logic [c_MAX_WIDTH-1:0] w_merge_result;
    logic [WIDTH-1:0]       w_merged;
    logic [WIDTH-1:0]       w_d_word;
    logic [WIDTH-1:0]       w_i_word;
    logic [WIDTH-1:0]       r_d_out;
    logic [WIDTH-1:0]       r_i_out;
    logic                   r_misaligned;
    logic                   r_oor;

    mem_init_fsm #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_BITS    (c_IDX_BITS)
    ) u_init_fsm (
        .clk         (clk),
        .rst         (reset),
        .o_ready     (w_ready),
        .o_clear_we  (w_clear_we),
        .o_clear_idx (w_clear_idx)
    );

    assign w_d_idx = dAddress[c_OFFSET_BITS +: c_IDX_BITS];
    assign w_i_idx = iAddress[c_OFFSET_BITS +: c_IDX_BITS];

    generate
        if (c_OFFSET_BITS > 0) begin : g_offset
            logic w_unused_ioffset;
            assign w_d_misaligned   = |dAddress[c_OFFSET_BITS-1:0];
            assign w_unused_ioffset = ^iAddress[c_OFFSET_BITS-1:0];
        end else begin : g_no_offset
            assign w_d_misaligned = 1'b0;
        end

        if (c_TOP_BIT < ADDR_WIDTH) begin : g_range
            assign w_d_oor = |dAddress[ADDR_WIDTH-1:c_TOP_BIT];
            assign w_i_oor = |iAddress[ADDR_WIDTH-1:c_TOP_BIT];
        end else begin : g_no_range
            assign w_d_oor = 1'b0;
            assign w_i_oor = 1'b0;
        end
    endgenerate

    assign w_user_we = w_ready & dWriteEnable & ~w_d_misaligned & ~w_d_oor;

    always_comb begin
        w_old_ext                = '0;
        w_new_ext                = '0;
        w_mask_ext               = '0;
        w_old_ext[WIDTH-1:0]     = r_mem[w_d_idx];
        w_new_ext[WIDTH-1:0]     = dDataIn;
        w_mask_ext[c_LANES-1:0]  = dByteEnable;
        w_merge_result           = merge_bytes(w_old_ext, w_new_ext, w_mask_ext);
    end

    logic w_unused_merge_hi;
    assign w_unused_merge_hi = |w_merge_result[c_MAX_WIDTH-1:WIDTH];
    assign w_merged          = w_merge_result[WIDTH-1:0];

    // Write-first: a same-cycle write is visible on both read ports.
    assign w_d_word = w_user_we ? w_merged : r_mem[w_d_idx];
    assign w_i_word = w_i_oor                          ? '0 :
                      (w_user_we && w_i_idx == w_d_idx) ? w_merged :
                                                          r_mem[w_i_idx];

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_clear_we) begin
                r_mem[w_clear_idx] <= '0;
            end else if (w_user_we) begin
                r_mem[w_d_idx] <= w_merged;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !w_ready) begin
            r_d_out      <= '0;
            r_i_out      <= '0;
            r_misaligned <= 1'b0;
            r_oor        <= 1'b0;
        end else begin
            r_d_out      <= w_d_oor ? '0 : w_d_word;
            r_i_out      <= w_i_word;
            r_misaligned <= w_d_misaligned;
            r_oor        <= w_d_oor;
        end
    end

`ifdef DUAL_PORT_MEMORY_PARITY_EN
    logic [c_LANES-1:0] r_par [DEPTH_WORDS];
    logic [c_LANES-1:0] w_par_new;
    logic [c_LANES-1:0] w_par_read;
    logic [c_LANES-1:0] w_par_calc;
    logic               r_perr;

    always_comb begin
        w_par_new  = '0;
        w_par_calc = '0;
        for (int k = 0; k < c_LANES; k++) begin
            w_par_new[k]  = dByteEnable[k] ? ^dDataIn[8*k +: 8] : r_par[w_d_idx][k];
            w_par_calc[k] = ^w_d_word[8*k +: 8];
        end
    end

    assign w_par_read = w_user_we ? w_par_new : r_par[w_d_idx];

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_clear_we) begin
                r_par[w_clear_idx] <= '0;
            end else if (w_user_we) begin
                r_par[w_d_idx] <= w_par_new;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !w_ready) begin
            r_perr <= 1'b0;
        end else begin
            r_perr <= ~w_d_oor & (w_par_calc != w_par_read);
        end
    end

    assign parityError = r_perr;
`else
    assign parityError = 1'b0;
`endif

    assign ready       = w_ready;
    assign iDataOut    = r_i_out;
    assign dDataOut    = r_d_out;
    assign dMisaligned = r_misaligned;
    assign dOutOfRange = r_oor;

endmodule
`default_nettype wire

// File: tb/tb_dual_port_memory.sv
`default_nettype none
// ============================================================================
// Module   : tb_dual_port_memory
// Purpose  : Directed self-checking bench for dual_port_memory (16 x 32-bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dual_port_memory;

    logic        clk;
    logic        reset;
    logic        ready;
    logic [31:0] iAddress;
    logic [31:0] iDataOut;
    logic [31:0] dAddress;
    logic        dWriteEnable;
    logic [3:0]  dByteEnable;
    logic [31:0] dDataIn;
    logic [31:0] dDataOut;
    logic        dMisaligned;
    logic        dOutOfRange;
    logic        parityError;

    int n_checks = 0;
    int n_fail   = 0;

    dual_port_memory #(
        .ADDR_WIDTH  (32),
        .DEPTH_WORDS (16),
        .WIDTH       (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ready        (ready),
        .iAddress     (iAddress),
        .iDataOut     (iDataOut),
        .dAddress     (dAddress),
        .dWriteEnable (dWriteEnable),
        .dByteEnable  (dByteEnable),
        .dDataIn      (dDataIn),
        .dDataOut     (dDataOut),
        .dMisaligned  (dMisaligned),
        .dOutOfRange  (dOutOfRange),
        .parityError  (parityError)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int cycles;
        reset = 1'b1;
        step();
        step();
        n_checks++;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", ready); end
        n_checks++;
        if (dDataOut !== 32'h0 || iDataOut !== 32'h0) begin
            n_fail++; $display("FAIL reset_data d=%h i=%h exp=0", dDataOut, iDataOut);
        end
        n_checks++;
        if (dMisaligned !== 1'b0 || dOutOfRange !== 1'b0 || parityError !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags mis=%b oor=%b par=%b exp=0", dMisaligned, dOutOfRange, parityError);
        end
        reset = 1'b0;
        cycles = 0;
        while (ready !== 1'b1 && cycles < 40) begin
            step();
            cycles++;
        end
        n_checks++;
        if (cycles != 16) begin n_fail++; $display("FAIL init_length got=%0d exp=16", cycles); end
        dAddress = 32'h0;
        iAddress = 32'h3C;
        step();
        n_checks++;
        if (dDataOut !== 32'h0 || iDataOut !== 32'h0) begin
            n_fail++; $display("FAIL init_cleared d=%h i=%h exp=0", dDataOut, iDataOut);
        end
    endtask

    task automatic test_full_write();
        dAddress = 32'h8; dWriteEnable = 1'b1; dByteEnable = 4'b1111;
        dDataIn = 32'hDEADBEEF; iAddress = 32'h0;
        step();
        n_checks++;
        if (dDataOut !== 32'hDEADBEEF) begin n_fail++; $display("FAIL write_first got=%h exp=deadbeef", dDataOut); end
        dWriteEnable = 1'b0; iAddress = 32'h8;
        step();
        n_checks++;
        if (dDataOut !== 32'hDEADBEEF || iDataOut !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL full_readback d=%h i=%h exp=deadbeef", dDataOut, iDataOut);
        end
    endtask

    task automatic test_byte_lane();
        dAddress = 32'h8; iAddress = 32'h8; dWriteEnable = 1'b1;
        dByteEnable = 4'b0010; dDataIn = 32'h00005500;
        step();
        n_checks++;
        if (dDataOut !== 32'hDEAD55EF || iDataOut !== 32'hDEAD55EF) begin
            n_fail++; $display("FAIL byte_lane d=%h i=%h exp=dead55ef", dDataOut, iDataOut);
        end
        // Zero byte enable with write request behaves as a plain read.
        dByteEnable = 4'b0000; dDataIn = 32'hFFFFFFFF; iAddress = 32'hA;
        step();
        n_checks++;
        if (dDataOut !== 32'hDEAD55EF || iDataOut !== 32'hDEAD55EF) begin
            n_fail++; $display("FAIL zero_mask d=%h i=%h exp=dead55ef", dDataOut, iDataOut);
        end
        dWriteEnable = 1'b0;
    endtask

    task automatic test_misaligned();
        dAddress = 32'h6; dWriteEnable = 1'b1; dByteEnable = 4'b1111; dDataIn = 32'h12345678;
        step();
        n_checks++;
        if (dMisaligned !== 1'b1 || dDataOut !== 32'h0) begin
            n_fail++; $display("FAIL misaligned_flag mis=%b d=%h exp=1/0", dMisaligned, dDataOut);
        end
        dWriteEnable = 1'b0; dAddress = 32'h4;
        step();
        n_checks++;
        if (dMisaligned !== 1'b0 || dDataOut !== 32'h0) begin
            n_fail++; $display("FAIL misaligned_suppress mis=%b d=%h exp=0/0", dMisaligned, dDataOut);
        end
    endtask

    task automatic test_out_of_range();
        dAddress = 32'h40; dWriteEnable = 1'b1; dByteEnable = 4'b1111;
        dDataIn = 32'hFFFFFFFF; iAddress = 32'h48;
        step();
        n_checks++;
        if (dOutOfRange !== 1'b1 || dDataOut !== 32'h0) begin
            n_fail++; $display("FAIL oor_flag oor=%b d=%h exp=1/0", dOutOfRange, dDataOut);
        end
        n_checks++;
        if (iDataOut !== 32'h0) begin n_fail++; $display("FAIL oor_instr got=%h exp=0", iDataOut); end
        dWriteEnable = 1'b0; dAddress = 32'h0; iAddress = 32'h8;
        step();
        n_checks++;
        if (dOutOfRange !== 1'b0 || dDataOut !== 32'h0 || iDataOut !== 32'hDEAD55EF) begin
            n_fail++; $display("FAIL oor_suppress oor=%b d=%h i=%h exp=0/0/dead55ef", dOutOfRange, dDataOut, iDataOut);
        end
    endtask

    task automatic test_back_to_back();
        dWriteEnable = 1'b1; dByteEnable = 4'b1111;
        dAddress = 32'h0; dDataIn = 32'hA0A0A0A0;
        step();
        n_checks++;
        if (dDataOut !== 32'hA0A0A0A0) begin n_fail++; $display("FAIL b2b_w0 got=%h exp=a0a0a0a0", dDataOut); end
        dAddress = 32'h4; dDataIn = 32'hB1B1B1B1;
        step();
        n_checks++;
        if (dDataOut !== 32'hB1B1B1B1) begin n_fail++; $display("FAIL b2b_w1 got=%h exp=b1b1b1b1", dDataOut); end
        dAddress = 32'hC; dDataIn = 32'hC2C2C2C2; iAddress = 32'h0;
        step();
        n_checks++;
        if (dDataOut !== 32'hC2C2C2C2 || iDataOut !== 32'hA0A0A0A0) begin
            n_fail++; $display("FAIL b2b_w2 d=%h i=%h exp=c2c2c2c2/a0a0a0a0", dDataOut, iDataOut);
        end
        dWriteEnable = 1'b0; dAddress = 32'h0; iAddress = 32'hC;
        step();
        n_checks++;
        if (dDataOut !== 32'hA0A0A0A0 || iDataOut !== 32'hC2C2C2C2) begin
            n_fail++; $display("FAIL b2b_r0 d=%h i=%h exp=a0a0a0a0/c2c2c2c2", dDataOut, iDataOut);
        end
        dAddress = 32'h4; iAddress = 32'h8;
        step();
        n_checks++;
        if (dDataOut !== 32'hB1B1B1B1 || iDataOut !== 32'hDEAD55EF) begin
            n_fail++; $display("FAIL b2b_r1 d=%h i=%h exp=b1b1b1b1/dead55ef", dDataOut, iDataOut);
        end
    endtask

`ifdef DUAL_PORT_MEMORY_PARITY_EN
    task automatic test_parity();
        dAddress = 32'h8; dWriteEnable = 1'b1; dByteEnable = 4'b1111; dDataIn = 32'h11223344;
        step();
        dWriteEnable = 1'b0;
        n_checks++;
        if (parityError !== 1'b0) begin n_fail++; $display("FAIL parity_clean got=%b exp=0", parityError); end
        dut.r_mem[2][3] = ~dut.r_mem[2][3];
        step();
        n_checks++;
        if (parityError !== 1'b1 || dDataOut !== 32'h1122334C) begin
            n_fail++; $display("FAIL parity_error par=%b d=%h exp=1/1122334c", parityError, dDataOut);
        end
        dAddress = 32'h4;
        step();
        n_checks++;
        if (parityError !== 1'b0) begin n_fail++; $display("FAIL parity_other got=%b exp=0", parityError); end
    endtask
`endif

    task automatic test_reset_in_init();
        int cycles;
        reset = 1'b1;
        step();
        reset = 1'b0;
        dAddress = 32'h8; iAddress = 32'h8; dWriteEnable = 1'b1;
        dByteEnable = 4'b1111; dDataIn = 32'hAAAAAAAA;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (ready !== 1'b0 || dDataOut !== 32'h0 || iDataOut !== 32'h0) begin
                n_fail++; $display("FAIL init_quiet cyc=%0d rdy=%b d=%h i=%h exp=0", i, ready, dDataOut, iDataOut);
            end
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        cycles = 0;
        while (ready !== 1'b1 && cycles < 40) begin
            step();
            cycles++;
        end
        dWriteEnable = 1'b0;
        n_checks++;
        if (cycles != 16) begin n_fail++; $display("FAIL reinit_length got=%0d exp=16", cycles); end
        step();
        n_checks++;
        if (dDataOut !== 32'h0 || iDataOut !== 32'h0) begin
            n_fail++; $display("FAIL reinit_cleared d=%h i=%h exp=0", dDataOut, iDataOut);
        end
    endtask

    initial begin
        reset = 1'b1; iAddress = '0; dAddress = '0;
        dWriteEnable = 1'b0; dByteEnable = '0; dDataIn = '0;
        test_reset();
        test_full_write();
        test_byte_lane();
        test_misaligned();
        test_out_of_range();
        test_back_to_back();
`ifdef DUAL_PORT_MEMORY_PARITY_EN
        test_parity();
`endif
        test_reset_in_init();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
